// File: rtl/alu_sequencer.sv
// Multicycle control sequencer for the 8-bit ALU: instruction fetch/decode,
// 4x8 register file, zero/carry flags, jumps, input handshake and output strobe.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic [7:0] alu_ra,
  output logic [7:0] alu_rb,
  output logic [3:0] alu_op,
  input  logic [9:0] alu_out,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       zflag,
  output logic       cflag,
  output logic       halted
);

  localparam int DATA_W = 8;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_OUT  = 4'd6;
  localparam logic [3:0] OP_IN   = 4'd7;
  localparam logic [3:0] OP_MOV  = 4'd8;
  localparam logic [3:0] OP_JZ   = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_IMM1,
    S_IMM2,
    S_HALT
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   pc, pc_nxt;
  logic [DATA_W-1:0]   ir, ir_nxt;
  logic [DATA_W-1:0]   regs [4];
  logic                zf, cf;
  logic [3:0]          ir_op, dec_op;
  logic [1:0]          ir_a, ir_b;
  logic                reg_we, flag_we, out_we;
  logic                taken;

  // Only the arithmetic/logic group (add..shr) touches the flags.
  function automatic logic sets_flags(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  function automatic logic is_jump(input logic [3:0] op);
    return (op == OP_JZ) || (op == OP_JMP);
  endfunction

  assign ir_op  = ir[7:4];
  assign ir_a   = ir[3:2];
  assign ir_b   = ir[1:0];
  assign dec_op = imem_data[7:4];

  // pc already points at the immediate byte while in IMM1.
  assign imem_addr = pc;
  assign halted    = (state == S_HALT);
  assign zflag     = zf;
  assign cflag     = cf;
  assign taken     = (ir_op == OP_JMP) || ((ir_op == OP_JZ) && zf);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    alu_op    = 4'd0;
    alu_ra    = '0;
    alu_rb    = '0;
    in_ready  = 1'b0;
    reg_we    = 1'b0;
    flag_we   = 1'b0;
    out_we    = 1'b0;
    case (state)
      S_FETCH: begin
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ir_nxt = imem_data;
        pc_nxt = pc + 8'd1;
        if (is_jump(dec_op)) begin
          state_nxt = S_IMM1;
        end else if (dec_op == OP_HALT) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op    = ir_op;
        alu_ra    = regs[ir_a];
        alu_rb    = (ir_op == OP_IN) ? in_data : regs[ir_b];
        state_nxt = S_FETCH;
        if (sets_flags(ir_op)) begin
          reg_we  = 1'b1;
          flag_we = 1'b1;
        end else if (ir_op == OP_OUT) begin
          out_we = 1'b1;
        end else if (ir_op == OP_IN) begin
          // Stall here until the input side offers a byte.
          in_ready = 1'b1;
          if (in_valid) begin
            reg_we = 1'b1;
          end else begin
            state_nxt = S_EXEC;
          end
        end else if (ir_op == OP_MOV) begin
          reg_we = 1'b1;
        end
      end
      S_IMM1: begin
        state_nxt = S_IMM2;
      end
      S_IMM2: begin
        pc_nxt    = taken ? imem_data : pc + 8'd1;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= '0;
      zf        <= 1'b0;
      cf        <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      ir        <= ir_nxt;
      out_valid <= out_we;
      if (reg_we) begin
        regs[ir_a] <= alu_out[7:0];
      end
      if (flag_we) begin
        zf <= alu_out[9];
        cf <= alu_out[8];
      end
      if (out_we) begin
        out_data <= regs[ir_a];
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: instruction-level reference model predicts out strobes,
// fetch addresses/cycles, input stalls and halt timing; a monitor compares them.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] imem_addr;
  logic [7:0] imem_data = 8'h00;
  logic [7:0] alu_ra, alu_rb;
  logic [3:0] alu_op;
  logic [9:0] alu_out;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       zflag, cflag, halted;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_op(alu_op), .alu_out(alu_out),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .zflag(zflag), .cflag(cflag), .halted(halted)
  );

  typedef struct { int cyc; logic [7:0] d; logic z; logic c; } out_t;
  typedef struct { int cyc; logic [7:0] a; } fet_t;

  logic [7:0] mem [256];
  bit         vpat [4096];
  logic [7:0] indata [64];
  out_t       oq [$];
  fet_t       fq [$];
  out_t       mo;
  fet_t       mf;
  int         checks, errors;
  int         cyc;
  int         ip;
  int         halt_cyc, exp_rdy, rdy_cnt;
  logic       exp_z, exp_c;
  bit         mon_en;
  bit         xfer;

  // Combinational 8-bit ALU of the board
  function automatic logic [9:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       cy;
    r  = 8'h00;
    cy = 1'b0;
    case (op)
      4'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; cy = s[8]; end
      4'd2: begin r = a - b; cy = (a < b); end
      4'd3: r = ~(a & b);
      4'd4: begin r = {a[6:0], 1'b0}; cy = a[7]; end
      4'd5: begin r = {1'b0, a[7:1]}; cy = a[0]; end
      4'd7, 4'd8: r = b;
      default: r = 8'h00;
    endcase
    return {(r == 8'h00), cy, r};
  endfunction

  assign alu_out = alu_f(alu_op, alu_ra, alu_rb);

  always @(posedge clk) imem_data <= mem[imem_addr];
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Input side: in_valid follows the per-cycle pattern, in_data the next queued byte.
  initial begin
    in_valid = 1'b0;
    in_data  = 8'h00;
    ip       = 0;
    forever begin
      @(negedge clk);
      xfer = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!rst_n) ip = 0;
      else if (xfer) ip++;
      in_valid = (cyc < 4096) ? vpat[cyc] : 1'b1;
      in_data  = indata[ip & 63];
    end
  end

  // Instruction-level reference: walks the program, producing timed expectations.
  task automatic iss();
    logic [7:0] pc, ins, imm;
    logic [7:0] r [4];
    logic [9:0] res;
    logic [3:0] op;
    logic [1:0] a, b;
    logic       z, c;
    int         t, k, e;
    out_t       o;
    fet_t       f;
    oq.delete();
    fq.delete();
    for (int i = 0; i < 4; i++) r[i] = 8'h00;
    pc = 8'h00; z = 1'b0; c = 1'b0; t = 0; k = 0; exp_rdy = 0; halt_cyc = -1;
    for (int steps = 0; steps < 500 && halt_cyc < 0; steps++) begin
      f.cyc = t; f.a = pc; fq.push_back(f);
      ins = mem[pc];
      op = ins[7:4]; a = ins[3:2]; b = ins[1:0];
      pc = pc + 8'd1;
      case (op)
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
          res = alu_f(op, r[a], r[b]);
          r[a] = res[7:0]; c = res[8]; z = res[9];
          t += 3;
        end
        4'd6: begin
          o.cyc = t + 3; o.d = r[a]; o.z = z; o.c = c; oq.push_back(o);
          t += 3;
        end
        4'd7: begin
          e = t + 2;
          while (e < 4095 && !vpat[e]) e++;
          exp_rdy += e - t - 1;
          r[a] = indata[k & 63];
          k++;
          t = e + 1;
        end
        4'd8: begin r[a] = r[b]; t += 3; end
        4'd9, 4'd10: begin
          f.cyc = t + 2; f.a = pc; fq.push_back(f);
          imm = mem[pc];
          pc = (op == 4'd10 || z) ? imm : pc + 8'd1;
          t += 4;
        end
        4'd11: halt_cyc = t + 2;
        default: t += 3;
      endcase
    end
    if (halt_cyc < 0) halt_cyc = t;
    exp_z = z;
    exp_c = c;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (oq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid cycle=%0d out_data=%0h expected no strobe", cyc, out_data);
        end else begin
          mo = oq.pop_front();
          chk("out_data", 32'(out_data), 32'(mo.d));
          chk("out_cycle", 32'(cyc), 32'(mo.cyc));
          chk("zflag_at_out", 32'(zflag), 32'(mo.z));
          chk("cflag_at_out", 32'(cflag), 32'(mo.c));
        end
      end
      if (fq.size() > 0 && fq[0].cyc == cyc) begin
        mf = fq.pop_front();
        chk("fetch_addr", 32'(imem_addr), 32'(mf.a));
      end
      if (in_ready) rdy_cnt++;
      if (cyc == halt_cyc - 1) chk("halted_early", 32'(halted), 32'd0);
      if (cyc == halt_cyc) chk("halted_on_time", 32'(halted), 32'd1);
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 256; i++) mem[i] = 8'hB0;
    for (int i = 0; i < 4096; i++) vpat[i] = 1'b1;
    for (int i = 0; i < 64; i++) indata[i] = 8'h00;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, ".imem_addr"}, 32'(imem_addr), 32'd0);
    chk({name, ".out_data"}, 32'(out_data), 32'd0);
    chk({name, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({name, ".zflag"}, 32'(zflag), 32'd0);
    chk({name, ".cflag"}, 32'(cflag), 32'd0);
    chk({name, ".halted"}, 32'(halted), 32'd0);
    chk({name, ".in_ready"}, 32'(in_ready), 32'd0);
    chk({name, ".alu_bus"}, {12'd0, alu_op, alu_ra, alu_rb}, 32'd0);
  endtask

  task automatic run_prog(input string name);
    iss();
    rdy_cnt = 0;
    do_reset();
    mon_en = 1'b1;
    while (cyc < halt_cyc + 20) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    chk({name, ".outs_missing"}, 32'(oq.size()), 32'd0);
    chk({name, ".fetches_missing"}, 32'(fq.size()), 32'd0);
    chk({name, ".in_ready_cycles"}, 32'(rdy_cnt), 32'(exp_rdy));
    chk({name, ".halted_end"}, 32'(halted), 32'd1);
    chk({name, ".zflag_end"}, 32'(zflag), 32'(exp_z));
    chk({name, ".cflag_end"}, 32'(cflag), 32'(exp_c));
  endtask

  task automatic gen_random();
    logic [7:0] ins [48];
    int         addr [48];
    int         n, m, a, j, r;
    logic [3:0] op;
    clear_all();
    n = 24 + $urandom_range(0, 8);
    m = n + 5;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 19);
      case (r)
        0, 1:          op = 4'd1;
        2, 3:          op = 4'd2;
        4:             op = 4'd3;
        5:             op = 4'd4;
        6:             op = 4'd5;
        7, 8:          op = 4'd6;
        9, 10, 11, 19: op = 4'd7;
        12, 13:        op = 4'd8;
        14, 15:        op = 4'd9;
        16:            op = 4'd10;
        17:            op = 4'd0;
        default:       op = 4'(12 + $urandom_range(0, 3));
      endcase
      ins[i] = {op, 4'($urandom_range(0, 15))};
    end
    ins[n]     = 8'h60;
    ins[n + 1] = 8'h64;
    ins[n + 2] = 8'h68;
    ins[n + 3] = 8'h6C;
    ins[n + 4] = 8'hB0;
    a = 0;
    for (int i = 0; i < m; i++) begin
      addr[i] = a;
      a += (ins[i][7:4] == 4'd9 || ins[i][7:4] == 4'd10) ? 2 : 1;
    end
    for (int i = 0; i < m; i++) begin
      mem[addr[i]] = ins[i];
      if (ins[i][7:4] == 4'd9 || ins[i][7:4] == 4'd10) begin
        j = $urandom_range(n, i + 1);
        mem[addr[i] + 1] = 8'(addr[j]);
      end
    end
    for (int i = 0; i < 4096; i++) vpat[i] = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < 64; i++) indata[i] = 8'($urandom());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;

    // Reset values, then reset asserted during EXEC of add 0xFF+0x01
    clear_all();
    mem[0] = 8'h70; mem[1] = 8'h74; mem[2] = 8'h11;
    indata[0] = 8'hFF; indata[1] = 8'h01;
    do_reset();
    check_reset_outputs("reset");
    repeat (8) @(posedge clk);
    #1;
    chk("abort.exec_alu_op", 32'(alu_op), 32'd1);
    chk("abort.exec_alu_ra", 32'(alu_ra), 32'hFF);
    chk("abort.exec_alu_rb", 32'(alu_rb), 32'h01);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("abort");

    // Arithmetic and branching
    clear_all();
    mem[0] = 8'h70; mem[1] = 8'h74; mem[2] = 8'h11; mem[3] = 8'h60;
    mem[4] = 8'h20; mem[5] = 8'h90; mem[6] = 8'h20;
    mem[8'h20] = 8'h11; mem[8'h21] = 8'h90; mem[8'h22] = 8'h40; mem[8'h23] = 8'h60;
    mem[8'h24] = 8'hA0; mem[8'h25] = 8'h27; mem[8'h26] = 8'h60; mem[8'h27] = 8'hB0;
    indata[0] = 8'd5; indata[1] = 8'd3;
    run_prog("arith");

    // Input stall: in_valid low for five EXEC cycles, then 0xA5
    clear_all();
    mem[0] = 8'h70; mem[1] = 8'h60; mem[2] = 8'hB0;
    for (int i = 0; i < 7; i++) vpat[i] = 1'b0;
    indata[0] = 8'hA5;
    run_prog("stall");

    // pc wrap on increment: add at 0xFF falls through to 0x00
    clear_all();
    mem[0] = 8'h90; mem[1] = 8'h10; mem[2] = 8'hA0; mem[3] = 8'hFE;
    mem[8'hFE] = 8'h20; mem[8'hFF] = 8'h10;
    mem[8'h10] = 8'h60; mem[8'h11] = 8'hB0;
    run_prog("wrap_inc");

    // pc wrap on immediate fetch: jmp at 0xFF, target byte at 0x00
    clear_all();
    mem[0] = 8'hA0; mem[1] = 8'hFF; mem[8'hFF] = 8'hA0;
    mem[8'hA0] = 8'h70; mem[8'hA1] = 8'h60; mem[8'hA2] = 8'hB0;
    indata[0] = 8'h3C;
    run_prog("wrap_imm");

    // Carry/zero from 0xFF+0x01, unknown ops, mov keeps flags
    clear_all();
    mem[0] = 8'h70; mem[1] = 8'h74; mem[2] = 8'h11; mem[3] = 8'h60;
    mem[4] = 8'hC5; mem[5] = 8'hD0; mem[6] = 8'hE3; mem[7] = 8'hF9;
    mem[8] = 8'h60; mem[9] = 8'h84; mem[10] = 8'h64; mem[11] = 8'hB0;
    indata[0] = 8'hFF; indata[1] = 8'h01;
    run_prog("carry");

    for (int i = 0; i < 8; i++) begin
      gen_random();
      run_prog("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
